alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Issue/writeback controller that drives the 4-bit ALU, the opposite end of the ALU operand/result interface.
- Accepts 8-bit instructions over a valid/ready handshake and holds a 4-entry register file.
- Presents operands and select to the external ALU, captures its combinational result and writes it back.
- Emits register values on an output handshake; forms the core datapath controller of the 4-bit CPU.

Parameters:
DATA_W, 4, data/ALU width; ALU is fixed at 4, so only 4 is supported.
NREGS, 4, register file depth; register index is 2 bits.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction available
instr_ready  output  1  sequencer can accept instruction
instr  input  8  [7:6] op, [5:4] rd, [3:2] rs, [1:0] rt; LDI uses [3:0] as imm
alu_a  output  DATA_W  ALU operand A
alu_b  output  DATA_W  ALU operand B
alu_sel  output  1  0=add, 1=nand
alu_res  input  DATA_W  combinational ALU result
out_valid  output  1  output data valid
out_ready  input  1  consumer accepts output
out_data  output  DATA_W  register value emitted by OUT
flag_z  output  1  last ALU writeback was zero
flag_n  output  1  last ALU writeback bit 3 set

Behaviour:
- Opcodes: 00 ADD rd=rs+rt (mod 16); 01 NAND rd=~(rs&rt); 10 LDI rd=imm; 11 OUT emits reg[rs].
- Reset (async, rst_n low): state=IDLE; regs=0; alu_a=alu_b=0; alu_sel=0; out_valid=0; out_data=0; flags=0.
- On the first clk edge after rst_n deasserts: instr_ready=1.
- Reset mid-instruction aborts it. No partial writeback occurs.
- FSM states: IDLE, EXEC, WB, OUT.
- IDLE:
  - instr_ready=1. Transfer occurs on instr_valid & instr_ready; latch instr.
  - ADD/NAND -> EXEC. LDI writes reg[rd]=imm at the accept edge and stays in IDLE.
  - OUT -> OUT with out_data=reg[rs] and out_valid=1 registered at the accept edge.
- EXEC:
  - instr_ready=0.
  - alu_a/alu_b/alu_sel are registered from reg[rs]/reg[rt]/op[0] at the transition into EXEC, so they are stable for all of EXEC.
  - Next state is WB.
- WB:
  - alu_a/alu_b/alu_sel are still held.
  - At the end of WB, reg[rd]<=alu_res, flag_z<=(alu_res==0), flag_n<=alu_res[3].
  - Next state is IDLE.
- ADD/NAND latency: accept edge + 2 cycles. The result is readable by an instruction accepted in the next IDLE, so no hazard is possible.
- ALU operands persist after WB until the next ALU instruction. LDI and OUT never change alu_* or the flags.
- OUT:
  - out_valid held and out_data stable until out_valid & out_ready, then IDLE.
  - out_ready low stalls indefinitely. instr_ready=0 throughout.
- rd==rs or rd==rt is legal: operands are read before writeback.
- Throughput: ALU op 1 per 3 cycles; LDI 1 per cycle; OUT at least 2 cycles.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode constants OP_ADD, OP_NAND, OP_LDI, OP_OUT;
  - the state enum;
  - instruction field bit positions;
  - ALU_SEL_ADD=0, ALU_SEL_NAND=1.
- One natural sub-module, seq_regfile: 4x4 register file with 2 async read ports, 1 sync write port and async reset.
- The FSM and handshakes stay in the top module.

Test Plan:
- LDI r0,3; LDI r1,4; ADD r2,r0,r1; OUT r2 -> alu_a=3, alu_b=4, alu_sel=0 during EXEC/WB; out_data=7; flag_z=0, flag_n=0.
- NAND r3,r0,r1 (r0=3, r1=4); OUT r3 -> alu_sel=1; r3=4'hF; flag_n=1.
- LDI r0,F; LDI r1,B; ADD r0,r0,r1 -> r0=4'hA (-6), flag_n=1. LDI r0,C; LDI r1,4; ADD r2,r0,r1 -> r2=0, flag_z=1 (wrap-around). LDI r0,8; LDI r1,E; NAND -> 7.
- OUT r2 with out_ready low for 5 cycles -> out_valid and out_data held stable, instr_ready=0. Raise out_ready -> one transfer, then IDLE.
- Back-to-back: instr_valid held high with 4 LDIs -> 4 accepts in 4 cycles. ADD -> instr_ready low for exactly 2 cycles.
- Assert rst_n low during EXEC of ADD r2 (r2 previously 5) -> all outputs and regs immediately 0, no writeback. After release, instr_ready=1 at the next clk edge.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcodes, FSM states and instruction field positions
//               for the ALU issue/writeback sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_OUT  = 2'b11;

    localparam logic ALU_SEL_ADD  = 1'b0;
    localparam logic ALU_SEL_NAND = 1'b1;

    localparam int INSTR_OP_HI  = 7;
    localparam int INSTR_OP_LO  = 6;
    localparam int INSTR_RD_HI  = 5;
    localparam int INSTR_RD_LO  = 4;
    localparam int INSTR_RS_HI  = 3;
    localparam int INSTR_RS_LO  = 2;
    localparam int INSTR_RT_HI  = 1;
    localparam int INSTR_RT_LO  = 0;
    localparam int INSTR_IMM_HI = 3;
    localparam int INSTR_IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/seq_regfile.sv
`default_nettype none
// ============================================================================
// Module      : seq_regfile
// Description : Small register file, two asynchronous read ports, one
//               synchronous write port, asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_regfile #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(NREGS)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(NREGS)-1:0]   raddr_a,
    output logic [DATA_W-1:0]          rdata_a,
    input  logic [$clog2(NREGS)-1:0]   raddr_b,
    output logic [DATA_W-1:0]          rdata_b
);

    localparam int IDX_W = $clog2(NREGS);

    logic [DATA_W-1:0] rf [NREGS];

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_reg
            logic [DATA_W-1:0] reg_d;
            logic [DATA_W-1:0] reg_q;

            always_comb begin
                reg_d = reg_q;
                if (we && (waddr == IDX_W'(i))) begin
                    reg_d = wdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign rf[i] = reg_q;
        end
    endgenerate

    assign rdata_a = rf[raddr_a];
    assign rdata_b = rf[raddr_b];

endmodule : seq_regfile
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Issue/writeback controller for an external 4-bit ALU with a
//               4-entry register file and instruction/output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_sel,
    input  logic [DATA_W-1:0] alu_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              flag_z,
    output logic              flag_n
);

    localparam int IDX_W = $clog2(NREGS);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              alu_sel_q, alu_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_n_q, flag_n_d;

    logic              rf_we;
    logic [IDX_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] rdata_t;

    logic [1:0]        instr_op;
    logic [IDX_W-1:0]  instr_rd;
    logic [IDX_W-1:0]  instr_rs;
    logic [IDX_W-1:0]  instr_rt;
    logic [DATA_W-1:0] instr_imm;

    assign instr_op  = instr[INSTR_OP_HI:INSTR_OP_LO];
    assign instr_rd  = instr[INSTR_RD_HI:INSTR_RD_LO];
    assign instr_rs  = instr[INSTR_RS_HI:INSTR_RS_LO];
    assign instr_rt  = instr[INSTR_RT_HI:INSTR_RT_LO];
    assign instr_imm = instr[INSTR_IMM_HI:INSTR_IMM_LO];

    // Read ports follow the incoming instruction; operands are only consumed
    // at the accept edge, so no source latching is needed.
    seq_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (instr_rs),
        .rdata_a (rdata_s),
        .raddr_b (instr_rt),
        .rdata_b (rdata_t)
    );

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        rf_we       = 1'b0;
        rf_waddr    = rd_q;
        rf_wdata    = alu_res;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid && ready_q) begin
                    case (instr_op)
                        OP_ADD, OP_NAND: begin
                            state_d   = ST_EXEC;
                            rd_d      = instr_rd;
                            alu_a_d   = rdata_s;
                            alu_b_d   = rdata_t;
                            alu_sel_d = (instr_op == OP_NAND) ? ALU_SEL_NAND : ALU_SEL_ADD;
                        end
                        OP_LDI: begin
                            rf_we    = 1'b1;
                            rf_waddr = instr_rd;
                            rf_wdata = instr_imm;
                        end
                        default: begin
                            state_d     = ST_OUT;
                            out_valid_d = 1'b1;
                            out_data_d  = rdata_s;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we    = 1'b1;
                flag_z_d = (alu_res == '0);
                flag_n_d = alu_res[DATA_W-1];
                state_d  = ST_IDLE;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase

        // Ready is registered so it stays low throughout reset and rises on
        // the first edge after release.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= ALU_SEL_ADD;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rd_q        <= rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
        end
    end

    assign instr_ready = ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;

endmodule : alu_sequencer
`default_nettype wire
